// File: rtl/ctrl.sv
// Control unit for a small 8-bit accumulator-less CPU.
// It sequences instruction fetch, decode, operand fetch and data-memory
// access. All outputs are combinational, derived from the state, the
// instruction register and the current inputs.

package ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_ctrl_op_e;

    typedef enum logic [1:0] {
        ADDR_HOLD = 2'd0,
        ADDR_INC  = 2'd1,
        ADDR_LOAD = 2'd2
    } addr_register_op_e;

    typedef enum logic {
        ADDR_SEL_PC  = 1'b0,
        ADDR_SEL_MAR = 1'b1
    } addr_sel_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5,
        ALU_SHL  = 3'd6,
        ALU_SHR  = 3'd7
    } alu_op_e;

    typedef enum logic {
        REGS_HOLD  = 1'b0,
        REGS_WRITE = 1'b1
    } registers_op_e;

    typedef enum logic [1:0] {
        R0 = 2'd0,
        R1 = 2'd1,
        R2 = 2'd2,
        R3 = 2'd3
    } register_sel_e;

    typedef enum logic [1:0] {
        MUX_ALU  = 2'd0,
        MUX_MEM  = 2'd1,
        MUX_REG1 = 2'd2
    } mux_sel_e;

    typedef struct packed {
        logic negative;
        logic carry;
        logic zero;
    } alu_flag_t;

endpackage

module ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    output mem_ctrl_op_e              mem_ctrl_op,
    output addr_register_op_e         addr_reg_op,
    output addr_sel_e                 addr_sel,
    output alu_op_e                   alu_op,
    output registers_op_e             reg_op,
    output register_sel_e             reg_sel_in,
    output register_sel_e             reg_sel_1,
    output register_sel_e             reg_sel_2,
    output mux_sel_e                  mux_sel,
    input  logic [DATA_BUS_WIDTH-1:0] bus_data_in,
    input  logic                      mem_op_done,
    input  alu_flag_t                 alu_flags
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_OPERAND = 3'd2,
        S_MEMORY  = 3'd3,
        S_HALT    = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        I_ALU = 4'd0,
        I_MOV = 4'd1,
        I_LDI = 4'd2,
        I_LD  = 4'd3,
        I_ST  = 4'd4,
        I_LDA = 4'd5,
        I_JMP = 4'd6,
        I_HLT = 4'd7,
        I_NOP = 4'd8
    } instr_e;

    // Classify an opcode byte; anything not matching a defined pattern is a NOP.
    function automatic instr_e decode_instr(input logic [7:0] op);
        instr_e kind;
        kind = I_NOP;
        if (op[7] == 1'b0) begin
            kind = I_ALU;
        end else begin
            case (op[6:4])
                3'b000: kind = I_MOV;
                3'b001: kind = (op[1:0] == 2'b00) ? I_LDI : I_NOP;
                3'b010: kind = I_LD;
                3'b011: kind = I_ST;
                3'b100: kind = (op[3:0] == 4'b0000) ? I_LDA : I_NOP;
                3'b101: kind = (op[1:0] == 2'b00) ? I_JMP : I_NOP;
                3'b111: kind = (op[3:0] == 4'b1111) ? I_HLT : I_NOP;
                default: kind = I_NOP;
            endcase
        end
        return kind;
    endfunction

    // Jump condition: 00 always, 01 zero, 10 carry, 11 negative.
    function automatic logic jump_taken(input logic [1:0] cc, input alu_flag_t flags);
        logic taken;
        case (cc)
            2'b00:   taken = 1'b1;
            2'b01:   taken = flags.zero;
            2'b10:   taken = flags.carry;
            default: taken = flags.negative;
        endcase
        return taken;
    endfunction

    state_e     state_reg, state_next;
    logic [7:0] ir_reg, ir_next;
    // Set during the extra OPERAND cycle of LDA that steps PC past the operand.
    logic       lda_step_reg, lda_step_next;

    instr_e        instr;
    register_sel_e ir_dd;
    register_sel_e ir_ss;

    assign instr = decode_instr(ir_reg);
    assign ir_dd = register_sel_e'(ir_reg[3:2]);
    assign ir_ss = register_sel_e'(ir_reg[1:0]);

    // State, instruction register and LDA sub-step flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            ir_reg       <= 8'h00;
            lda_step_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ir_reg       <= ir_next;
            lda_step_reg <= lda_step_next;
        end
    end

    // Next-state and output decode; outputs stay idle while reset is high.
    always_comb begin
        mem_ctrl_op   = MEM_NOP;
        addr_reg_op   = ADDR_HOLD;
        addr_sel      = ADDR_SEL_PC;
        alu_op        = ALU_PASS;
        reg_op        = REGS_HOLD;
        reg_sel_in    = R0;
        reg_sel_1     = R0;
        reg_sel_2     = R0;
        mux_sel       = MUX_ALU;
        state_next    = state_reg;
        ir_next       = ir_reg;
        lda_step_next = lda_step_reg;

        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    addr_sel    = ADDR_SEL_PC;
                    mem_ctrl_op = MEM_READ;
                    if (mem_op_done) begin
                        ir_next     = bus_data_in[7:0];
                        addr_reg_op = ADDR_INC;
                        state_next  = S_DECODE;
                    end
                end

                S_DECODE: begin
                    case (instr)
                        I_ALU: begin
                            alu_op     = alu_op_e'(ir_reg[6:4]);
                            reg_sel_1  = ir_dd;
                            reg_sel_2  = ir_ss;
                            mux_sel    = MUX_ALU;
                            reg_op     = REGS_WRITE;
                            reg_sel_in = ir_dd;
                            state_next = S_FETCH;
                        end
                        I_MOV: begin
                            reg_sel_1  = ir_ss;
                            mux_sel    = MUX_REG1;
                            reg_op     = REGS_WRITE;
                            reg_sel_in = ir_dd;
                            state_next = S_FETCH;
                        end
                        I_LDI, I_LDA, I_JMP: begin
                            lda_step_next = 1'b0;
                            state_next    = S_OPERAND;
                        end
                        I_LD, I_ST: state_next = S_MEMORY;
                        I_HLT:      state_next = S_HALT;
                        default:    state_next = S_FETCH;
                    endcase
                end

                S_OPERAND: begin
                    addr_sel = ADDR_SEL_PC;
                    if (lda_step_reg) begin
                        // MAR already holds the target; now skip PC over the operand.
                        addr_reg_op   = ADDR_INC;
                        lda_step_next = 1'b0;
                        state_next    = S_FETCH;
                    end else begin
                        mem_ctrl_op = MEM_READ;
                        if (mem_op_done) begin
                            state_next = S_FETCH;
                            case (instr)
                                I_LDI: begin
                                    mux_sel     = MUX_MEM;
                                    reg_op      = REGS_WRITE;
                                    reg_sel_in  = ir_dd;
                                    addr_reg_op = ADDR_INC;
                                end
                                I_LDA: begin
                                    mux_sel       = MUX_MEM;
                                    addr_sel      = ADDR_SEL_MAR;
                                    addr_reg_op   = ADDR_LOAD;
                                    lda_step_next = 1'b1;
                                    state_next    = S_OPERAND;
                                end
                                I_JMP: begin
                                    if (jump_taken(ir_reg[3:2], alu_flags)) begin
                                        mux_sel     = MUX_MEM;
                                        addr_reg_op = ADDR_LOAD;
                                    end else begin
                                        addr_reg_op = ADDR_INC;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                S_MEMORY: begin
                    addr_sel = ADDR_SEL_MAR;
                    if (instr == I_ST) begin
                        mem_ctrl_op = MEM_WRITE;
                        reg_sel_1   = ir_ss;
                        mux_sel     = MUX_REG1;
                    end else begin
                        mem_ctrl_op = MEM_READ;
                        if (mem_op_done) begin
                            mux_sel    = MUX_MEM;
                            reg_op     = REGS_WRITE;
                            reg_sel_in = ir_dd;
                        end
                    end
                    if (mem_op_done) begin
                        state_next = S_FETCH;
                    end
                end

                S_HALT: state_next = S_HALT;

                default: state_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl.sv
// Directed bench for the ctrl sequencer. Each step drives one cycle of
// inputs and queues the expected output word; a negedge monitor pops and
// compares it against the DUT.

module tb_ctrl;
    import ctrl_pkg::*;

    logic              clock;
    logic              reset;
    logic [7:0]        bus_data_in;
    logic              mem_op_done;
    alu_flag_t         alu_flags;
    mem_ctrl_op_e      mem_ctrl_op;
    addr_register_op_e addr_reg_op;
    addr_sel_e         addr_sel;
    alu_op_e           alu_op;
    registers_op_e     reg_op;
    register_sel_e     reg_sel_in;
    register_sel_e     reg_sel_1;
    register_sel_e     reg_sel_2;
    mux_sel_e          mux_sel;

    typedef struct {
        string       tag;
        logic [16:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int checks   = 0;
    int failures = 0;

    logic [16:0] obs;
    logic [16:0] idle, rd_wait, rd_done;

    ctrl #(.DATA_BUS_WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_ctrl_op (mem_ctrl_op),
        .addr_reg_op (addr_reg_op),
        .addr_sel    (addr_sel),
        .alu_op      (alu_op),
        .reg_op      (reg_op),
        .reg_sel_in  (reg_sel_in),
        .reg_sel_1   (reg_sel_1),
        .reg_sel_2   (reg_sel_2),
        .mux_sel     (mux_sel),
        .bus_data_in (bus_data_in),
        .mem_op_done (mem_op_done),
        .alu_flags   (alu_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign obs = {mem_ctrl_op, addr_reg_op, addr_sel, alu_op, reg_op,
                  reg_sel_in, reg_sel_1, reg_sel_2, mux_sel};

    // Expected output word: mem, addr_op, addr_sel, alu, reg_op, sel_in, sel1, sel2, mux.
    function automatic logic [16:0] ev(input logic [1:0] m, input logic [1:0] a,
                                       input logic s, input logic [2:0] alu,
                                       input logic r, input logic [1:0] si,
                                       input logic [1:0] s1, input logic [1:0] s2,
                                       input logic [1:0] mx);
        return {m, a, s, alu, r, si, s1, s2, mx};
    endfunction

    // Scoreboard check at the falling edge, mid-cycle.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            sb_item_t item;
            item = sb.pop_front();
            checks++;
            assert (obs === item.exp)
            else begin
                failures++;
                $error("FAIL %s observed=%05h expected=%05h", item.tag, obs, item.exp);
            end
            $display("step %-12s observed=%05h expected=%05h", item.tag, obs, item.exp);
        end
    end

    task automatic step(input string tag, input logic rst, input logic done,
                        input logic [7:0] bus, input logic [2:0] flags,
                        input logic [16:0] exp);
        sb_item_t item;
        reset       = rst;
        mem_op_done = done;
        bus_data_in = bus;
        alu_flags   = alu_flag_t'(flags);
        item.tag    = tag;
        item.exp    = exp;
        sb.push_back(item);
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [16:0] st_exp;
        idle    = 17'h0;
        rd_wait = ev(2'd1, 2'd0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        rd_done = ev(2'd1, 2'd1, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        st_exp  = ev(2'd2, 2'd0, 1'b1, 3'd0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd2);

        reset = 1'b1; mem_op_done = 1'b0; bus_data_in = 8'h00; alu_flags = alu_flag_t'(3'b000);
        @(posedge clock);
        #1;

        // Reset: outputs idle even with done high.
        step("rst0", 1, 1, 8'hFF, 3'b000, idle);
        step("rst1", 1, 0, 8'h00, 3'b000, idle);

        // Fetch with three wait cycles, then ADD R2,R3.
        step("fwait0", 0, 0, 8'h00, 3'b000, rd_wait);
        step("fwait1", 0, 0, 8'h00, 3'b000, rd_wait);
        step("fwait2", 0, 0, 8'h00, 3'b000, rd_wait);
        step("fdone_add", 0, 1, 8'h1B, 3'b000, rd_done);
        step("dec_add", 0, 0, 8'h00, 3'b000, ev(2'd0, 2'd0, 1'b0, 3'd1, 1'b1, 2'd2, 2'd2, 2'd3, 2'd0));

        // LDI R1, 0x5A.
        step("fdone_ldi", 0, 1, 8'h94, 3'b000, rd_done);
        step("dec_ldi", 0, 0, 8'h00, 3'b000, idle);
        step("op_wait_ldi", 0, 0, 8'h00, 3'b000, rd_wait);
        step("op_done_ldi", 0, 1, 8'h5A, 3'b000, ev(2'd1, 2'd1, 1'b0, 3'd0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd1));

        // JMP Z taken then not taken.
        step("fdone_jz1", 0, 1, 8'hD4, 3'b000, rd_done);
        step("dec_jz1", 0, 0, 8'h00, 3'b000, idle);
        step("op_jz_take", 0, 1, 8'h20, 3'b001, ev(2'd1, 2'd2, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1));
        step("fdone_jz2", 0, 1, 8'hD4, 3'b000, rd_done);
        step("dec_jz2", 0, 0, 8'h00, 3'b000, idle);
        step("op_jz_skip", 0, 1, 8'h20, 3'b000, rd_done);

        // ST R2 with a two-cycle memory wait.
        step("fdone_st", 0, 1, 8'hB2, 3'b000, rd_done);
        step("dec_st", 0, 0, 8'h00, 3'b000, idle);
        step("st_wait0", 0, 0, 8'h00, 3'b000, st_exp);
        step("st_wait1", 0, 0, 8'h00, 3'b000, st_exp);
        step("st_done", 0, 1, 8'h00, 3'b000, st_exp);
        step("st_refetch", 0, 0, 8'h00, 3'b000, rd_wait);

        // LD R1 from memory.
        step("fdone_ld", 0, 1, 8'hA7, 3'b000, rd_done);
        step("dec_ld", 0, 0, 8'h00, 3'b000, idle);
        step("ld_wait", 0, 0, 8'h00, 3'b000, ev(2'd1, 2'd0, 1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
        step("ld_done", 0, 1, 8'h33, 3'b000, ev(2'd1, 2'd0, 1'b1, 3'd0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd1));

        // MOV R3,R2.
        step("fdone_mov", 0, 1, 8'h8E, 3'b000, rd_done);
        step("dec_mov", 0, 0, 8'h00, 3'b000, ev(2'd0, 2'd0, 1'b0, 3'd0, 1'b1, 2'd3, 2'd2, 2'd0, 2'd2));

        // LDA: MAR load, then the PC step cycle, then fetch.
        step("fdone_lda", 0, 1, 8'hC0, 3'b000, rd_done);
        step("dec_lda", 0, 0, 8'h00, 3'b000, idle);
        step("op_wait_lda", 0, 0, 8'h00, 3'b000, rd_wait);
        step("op_done_lda", 0, 1, 8'h40, 3'b000, ev(2'd1, 2'd2, 1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1));
        step("lda_pc_inc", 0, 1, 8'h00, 3'b000, ev(2'd0, 2'd1, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
        step("lda_refetch", 0, 0, 8'h00, 3'b000, rd_wait);

        // Undefined code 0x95 behaves as NOP.
        step("fdone_nop", 0, 1, 8'h95, 3'b000, rd_done);
        step("dec_nop", 0, 0, 8'h00, 3'b000, idle);
        step("nop_refetch", 0, 0, 8'h00, 3'b000, rd_wait);

        // HLT stays idle, reset releases it into a fetch.
        step("fdone_hlt", 0, 1, 8'hFF, 3'b000, rd_done);
        step("dec_hlt", 0, 1, 8'h00, 3'b000, idle);
        step("halt0", 0, 1, 8'h1B, 3'b111, idle);
        step("halt1", 0, 1, 8'h1B, 3'b111, idle);
        step("halt2", 0, 0, 8'h00, 3'b000, idle);
        step("halt_rst", 1, 0, 8'h00, 3'b000, idle);
        step("halt_rel", 0, 0, 8'h00, 3'b000, rd_wait);

        // Reset in the middle of a store wait.
        step("fdone_st2", 0, 1, 8'hB2, 3'b000, rd_done);
        step("dec_st2", 0, 0, 8'h00, 3'b000, idle);
        step("st2_wait", 0, 0, 8'h00, 3'b000, st_exp);
        step("mem_rst", 1, 1, 8'h00, 3'b000, idle);
        step("mem_rel", 0, 0, 8'h00, 3'b000, rd_wait);

        // SUB R3,R1 after recovery.
        step("fdone_sub", 0, 1, 8'h2D, 3'b000, rd_done);
        step("dec_sub", 0, 0, 8'h00, 3'b000, ev(2'd0, 2'd0, 1'b0, 3'd2, 1'b1, 2'd3, 2'd3, 2'd1, 2'd0));

        // Let the monitor drain the last entry.
        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain observed=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl.md
CTRL -- requirements
Module: ctrl

Interface
REQ-001 SHALL have parameter DATA_BUS_WIDTH, default 8, instruction/data bus width.
REQ-002 SHALL have port clock, input, 1, sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have port mem_ctrl_op, output, mem_ctrl_op_e (2), memory op: NOP=0, READ=1, WRITE=2.
REQ-005 SHALL have port addr_reg_op, output, addr_register_op_e (2), address register op: HOLD=0, INC=1, LOAD=2 (load from bus).
REQ-006 SHALL have port addr_sel, output, addr_sel_e (1), address register select: PC=0, MAR=1.
REQ-007 SHALL have port alu_op, output, alu_op_e (3), ALU op: PASS=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SHL=6, SHR=7.
REQ-008 SHALL have port reg_op, output, registers_op_e (1), register file op: HOLD=0, WRITE=1.
REQ-009 SHALL have ports reg_sel_in, reg_sel_1 and reg_sel_2, each output, register_sel_e (2), write select, read port 1 and read port 2: R0..R3 = 0..3.
REQ-010 SHALL have port mux_sel, output, mux_sel_e (2), bus source: ALU=0, MEM=1, REG1=2.
REQ-011 SHALL have port bus_data_in, input, DATA_BUS_WIDTH, data from memory/bus.
REQ-012 SHALL have port mem_op_done, input, 1, memory handshake complete, valid the cycle it is high.
REQ-013 SHALL have port alu_flags, input, alu_flag_t (3), {negative[2], carry[1], zero[0]}, registered flags from the last ALU op.

Function
REQ-014 SHALL hold an 8-bit instruction register IR and a state register with states FETCH, DECODE, OPERAND, MEMORY, HALT.
REQ-015 SHALL drive outputs combinationally from state, IR and inputs; every output SHALL be 0 unless set by a rule below.
REQ-016 FETCH: addr_sel=PC and mem_ctrl_op=READ; while mem_op_done=0 the state SHALL remain FETCH; when mem_op_done=1, IR SHALL be loaded from bus_data_in[7:0], addr_reg_op=INC (PC), and the next state SHALL be DECODE.
REQ-017 Encoding: 0ooodd ss = ALU op ooo, with dd=bits[3:2] and ss=bits[1:0]; 1000ddss = MOV; 1001dd00 = LDI; 1010ddss = LD; 1011ddss = ST; 11000000 = LDA; 1101cc00 = JMP; 11111111 = HLT; every other code = NOP.
REQ-018 DECODE, ALU: alu_op=ooo, reg_sel_1=dd, reg_sel_2=ss, mux_sel=ALU, reg_op=WRITE, reg_sel_in=dd; next state FETCH.
REQ-019 DECODE, MOV: reg_sel_1=ss, mux_sel=REG1, reg_op=WRITE, reg_sel_in=dd; next state FETCH.
REQ-020 DECODE, LDI/LDA/JMP: outputs idle; next state OPERAND.
REQ-021 DECODE, LD/ST: outputs idle; next state MEMORY. HLT: next state HALT. NOP: next state FETCH.
REQ-022 OPERAND: addr_sel=PC and mem_ctrl_op=READ until mem_op_done=1. On completion:
- LDI: mux_sel=MEM, reg_op=WRITE, reg_sel_in=dd, addr_reg_op=INC.
- LDA: mux_sel=MEM, addr_sel=MAR, addr_reg_op=LOAD; PC not incremented, so operand skipping is done by PC INC on the next fetch path; LDA therefore also requires PC INC and SHALL use a second OPERAND cycle with addr_sel=PC, addr_reg_op=INC.
- JMP taken (cc=00 always, 01 zero, 10 carry, 11 negative, sampled from alu_flags in that cycle): mux_sel=MEM, addr_sel=PC, addr_reg_op=LOAD.
- JMP not taken: addr_sel=PC, addr_reg_op=INC.
- All cases: next state FETCH.
REQ-023 MEMORY: addr_sel=MAR. LD: mem_ctrl_op=READ; on mem_op_done=1, mux_sel=MEM, reg_op=WRITE, reg_sel_in=dd. ST: mem_ctrl_op=WRITE, reg_sel_1=ss, mux_sel=REG1. Hold the state until mem_op_done=1, then go to FETCH.
REQ-024 HALT: all outputs idle; the state SHALL remain HALT until reset.
REQ-025 mem_ctrl_op SHALL stay asserted continuously until mem_op_done; no register write or address update SHALL occur before done.

Reset
REQ-026 With reset=1 at a rising edge, state SHALL be FETCH and IR=0; during reset all outputs SHALL be 0 (no memory op).
REQ-027 Reset SHALL abort any in-progress instruction or memory wait; the first cycle after reset deassertion SHALL issue a FETCH READ at PC.

Verification
REQ-028 Reset, then mem_op_done=1 with bus_data_in=0x1B (ADD R2,R3) -> DECODE cycle shows alu_op=1, reg_sel_1=2, reg_sel_2=3, reg_sel_in=2, reg_op=1, mux_sel=0.
REQ-029 Fetch with mem_op_done held 0 for 3 cycles -> mem_ctrl_op=READ for 4 cycles and IR unchanged until done; PC INC exactly once.
REQ-030 LDI R1 (0x94), operand 0x5A -> in the OPERAND done cycle mux_sel=MEM, reg_sel_in=1, reg_op=WRITE, addr_reg_op=INC.
REQ-031 JMP Z (0xD4): alu_flags=3'b001 -> addr_reg_op=LOAD, addr_sel=PC; alu_flags=3'b000 -> addr_reg_op=INC.
REQ-032 ST R2 (0xB2) with a 2-cycle memory wait -> mem_ctrl_op=WRITE, addr_sel=MAR, reg_sel_1=2 throughout, then FETCH.
REQ-033 HLT (0xFF) -> outputs idle indefinitely; reset asserted mid-HALT or mid-MEMORY -> FETCH READ on the next cycle after release.
